// File: rtl/bram_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the block RAM.
interface bram_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   // requester A (Z80 bus interface)
   logic              a_req_i;
   logic              a_we_i;
   logic [ADDR_W-1:0] a_addr_i;
   logic [DATA_W-1:0] a_wdata_i;
   logic              a_ack_o;
   logic [DATA_W-1:0] a_rdata_o;
   // requester B (DMA engine)
   logic              b_req_i;
   logic              b_we_i;
   logic [ADDR_W-1:0] b_addr_i;
   logic [DATA_W-1:0] b_wdata_i;
   logic              b_ack_o;
   logic [DATA_W-1:0] b_rdata_o;
   // RAM side
   logic              mem_en_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   // arbiter view
   modport slave (
      input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
      output a_ack_o, a_rdata_o,
      input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
      output b_ack_o, b_rdata_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   // requester/RAM view
   modport master (
      output a_req_i, a_we_i, a_addr_i, a_wdata_i,
      input  a_ack_o, a_rdata_o,
      output b_req_i, b_we_i, b_addr_i, b_wdata_i,
      input  b_ack_o, b_rdata_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between
// requester A (CPU) and requester B (DMA). Each access runs
// IDLE -> ACCESS -> DONE; the next access may be issued straight from DONE.
module bram_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   bram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   // owner / last grant encoding: 0 = A, 1 = B
   logic              r_owner_b;
   logic              r_last_b;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_a_ack;
   logic              r_b_ack;

   logic              w_elig_a;
   logic              w_elig_b;
   logic              w_issue;
   logic              w_pick_b;

   logic              w_owner_b_nxt;
   logic              w_last_b_nxt;
   logic              w_mem_en_nxt;
   logic              w_mem_we_nxt;
   logic [ADDR_W-1:0] w_mem_addr_nxt;
   logic [DATA_W-1:0] w_mem_wdata_nxt;
   logic              w_a_ack_nxt;
   logic              w_b_ack_nxt;

   // Eligibility and winner; in DONE the owner is busy consuming its ack
   always_comb begin
      w_elig_a = 1'b0;
      w_elig_b = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_elig_a = bus.a_req_i;
            w_elig_b = bus.b_req_i;
         end
         S_DONE: begin
            w_elig_a = bus.a_req_i &  r_owner_b;
            w_elig_b = bus.b_req_i & ~r_owner_b;
         end
         default: begin
            w_elig_a = 1'b0;
            w_elig_b = 1'b0;
         end
      endcase
      w_issue  = w_elig_a | w_elig_b;
      // tie goes to whoever was not granted last
      w_pick_b = w_elig_b & (~w_elig_a | ~r_last_b);
   end

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   w_state_nxt = w_issue ? S_ACCESS : S_IDLE;
         S_ACCESS: w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = w_issue ? S_ACCESS : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered RAM controls, acks and grant tracking
   always_comb begin
      w_owner_b_nxt   = r_owner_b;
      w_last_b_nxt    = r_last_b;
      w_mem_en_nxt    = 1'b0;
      w_mem_we_nxt    = 1'b0;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_a_ack_nxt     = 1'b0;
      w_b_ack_nxt     = 1'b0;
      case (r_state)
         S_ACCESS: begin
            // RAM samples on this edge; flag completion to the owner
            w_a_ack_nxt = ~r_owner_b;
            w_b_ack_nxt =  r_owner_b;
         end
         S_IDLE, S_DONE: begin
            if (w_issue) begin
               w_owner_b_nxt   = w_pick_b;
               w_last_b_nxt    = w_pick_b;
               w_mem_en_nxt    = 1'b1;
               w_mem_we_nxt    = w_pick_b ? bus.b_we_i    : bus.a_we_i;
               w_mem_addr_nxt  = w_pick_b ? bus.b_addr_i  : bus.a_addr_i;
               w_mem_wdata_nxt = w_pick_b ? bus.b_wdata_i : bus.a_wdata_i;
            end
         end
         default: begin
            w_mem_en_nxt = 1'b0;
         end
      endcase
   end

   // Output and grant registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_owner_b   <= 1'b0;
         r_last_b    <= 1'b1;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_a_ack     <= 1'b0;
         r_b_ack     <= 1'b0;
      end else begin
         r_owner_b   <= w_owner_b_nxt;
         r_last_b    <= w_last_b_nxt;
         r_mem_en    <= w_mem_en_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_a_ack     <= w_a_ack_nxt;
         r_b_ack     <= w_b_ack_nxt;
      end
   end

   assign bus.mem_en_o    = r_mem_en;
   assign bus.mem_we_o    = r_mem_we;
   assign bus.mem_addr_o  = r_mem_addr;
   assign bus.mem_wdata_o = r_mem_wdata;
   assign bus.a_ack_o     = r_a_ack;
   assign bus.b_ack_o     = r_b_ack;
   // RAM output is already registered inside the RAM; share it with both ports
   assign bus.a_rdata_o   = bus.mem_rdata_i;
   assign bus.b_rdata_o   = bus.mem_rdata_i;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural synchronous RAM.
module tb_bram_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [7:0] ram [0:65535];

   bram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   bram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // synchronous single-port RAM: data valid the cycle after enable
   always @(posedge clk) begin
      if (bus.mem_en_o) begin
         if (bus.mem_we_o) ram[bus.mem_addr_o] = bus.mem_wdata_o;
         else              bus.mem_rdata_i <= ram[bus.mem_addr_o];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.a_req_i = 1'b0; bus.a_we_i = 1'b0; bus.a_addr_i = 16'h0; bus.a_wdata_i = 8'h0;
      bus.b_req_i = 1'b0; bus.b_we_i = 1'b0; bus.b_addr_i = 16'h0; bus.b_wdata_i = 8'h0;
      bus.mem_rdata_i = 8'h0;
      ram[16'h1234] = 8'hA5;
      ram[16'h0010] = 8'h61;
      ram[16'h0020] = 8'h72;
      for (int j = 0; j < 4; j++) begin
         ram[16'h0100 + 16'(j)] = 8'h40 + 8'(j);
         ram[16'h0200 + 16'(j)] = 8'h80 + 8'(j);
      end
      ram[16'h0000] = 8'h11;
      ram[16'h0001] = 8'h22;
      ram[16'h0400] = 8'h5A;

      // reset state
      tick();
      chk("rst_en",    32'(bus.mem_en_o),    32'h0);
      chk("rst_we",    32'(bus.mem_we_o),    32'h0);
      chk("rst_addr",  32'(bus.mem_addr_o),  32'h0);
      chk("rst_wdata", 32'(bus.mem_wdata_o), 32'h0);
      chk("rst_aack",  32'(bus.a_ack_o),     32'h0);
      chk("rst_back",  32'(bus.b_ack_o),     32'h0);
      tick();
      rst = 1'b0;
      tick();

      // A read 0x1234
      bus.a_req_i = 1'b1; bus.a_we_i = 1'b0; bus.a_addr_i = 16'h1234;
      tick();
      chk("t1_en",   32'(bus.mem_en_o),   32'h1);
      chk("t1_we",   32'(bus.mem_we_o),   32'h0);
      chk("t1_addr", 32'(bus.mem_addr_o), 32'h1234);
      chk("t1_aack0", 32'(bus.a_ack_o),   32'h0);
      tick();
      chk("t1_aack", 32'(bus.a_ack_o),   32'h1);
      chk("t1_rd",   32'(bus.a_rdata_o), 32'hA5);
      chk("t1_back", 32'(bus.b_ack_o),   32'h0);
      chk("t1_en_off", 32'(bus.mem_en_o), 32'h0);
      bus.a_req_i = 1'b0;
      tick();
      chk("t1_idle_ack", 32'(bus.a_ack_o),  32'h0);
      chk("t1_idle_en",  32'(bus.mem_en_o), 32'h0);

      // B write 0x3C to 0xFFFF then read back
      bus.b_req_i = 1'b1; bus.b_we_i = 1'b1; bus.b_addr_i = 16'hFFFF; bus.b_wdata_i = 8'h3C;
      tick();
      chk("t2w_en",    32'(bus.mem_en_o),    32'h1);
      chk("t2w_we",    32'(bus.mem_we_o),    32'h1);
      chk("t2w_addr",  32'(bus.mem_addr_o),  32'hFFFF);
      chk("t2w_wdata", 32'(bus.mem_wdata_o), 32'h3C);
      tick();
      chk("t2w_back", 32'(bus.b_ack_o),   32'h1);
      chk("t2w_aack", 32'(bus.a_ack_o),   32'h0);
      chk("t2w_ram",  32'(ram[16'hFFFF]), 32'h3C);
      bus.b_we_i = 1'b0;
      tick();
      chk("t2_idle_en",  32'(bus.mem_en_o), 32'h0);
      chk("t2_idle_ack", 32'(bus.b_ack_o),  32'h0);
      tick();
      chk("t2r_en", 32'(bus.mem_en_o), 32'h1);
      chk("t2r_we", 32'(bus.mem_we_o), 32'h0);
      tick();
      chk("t2r_back", 32'(bus.b_ack_o),   32'h1);
      chk("t2r_rd",   32'(bus.b_rdata_o), 32'h3C);
      bus.b_req_i = 1'b0;
      tick();

      // fresh reset, simultaneous requests: A first
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      bus.a_req_i = 1'b1; bus.a_addr_i = 16'h0010;
      bus.b_req_i = 1'b1; bus.b_addr_i = 16'h0020;
      tick();
      chk("t3_addrA", 32'(bus.mem_addr_o), 32'h0010);
      tick();
      chk("t3_aack", 32'(bus.a_ack_o),   32'h1);
      chk("t3_back0", 32'(bus.b_ack_o),  32'h0);
      chk("t3_rdA",  32'(bus.a_rdata_o), 32'h61);
      bus.a_req_i = 1'b0;
      tick();
      chk("t3_enB",   32'(bus.mem_en_o),   32'h1);
      chk("t3_addrB", 32'(bus.mem_addr_o), 32'h0020);
      chk("t3_noack", 32'(bus.a_ack_o | bus.b_ack_o), 32'h0);
      tick();
      chk("t3_back", 32'(bus.b_ack_o),   32'h1);
      chk("t3_rdB",  32'(bus.b_rdata_o), 32'h72);
      bus.b_req_i = 1'b0;
      tick();

      // full contention: A,B,A,B... one issue every 2 cycles
      bus.a_req_i = 1'b1; bus.a_addr_i = 16'h0100;
      bus.b_req_i = 1'b1; bus.b_addr_i = 16'h0200;
      for (int k = 0; k < 8; k++) begin
         logic        is_b;
         logic [15:0] j;
         is_b = k[0];
         j    = 16'(k / 2);
         tick();
         chk("t4_en",    32'(bus.mem_en_o), 32'h1);
         chk("t4_addr",  32'(bus.mem_addr_o), is_b ? 32'(16'h0200 + j) : 32'(16'h0100 + j));
         chk("t4_noack", 32'(bus.a_ack_o | bus.b_ack_o), 32'h0);
         tick();
         chk("t4_aack", 32'(bus.a_ack_o), is_b ? 32'h0 : 32'h1);
         chk("t4_back", 32'(bus.b_ack_o), is_b ? 32'h1 : 32'h0);
         chk("t4_rd", is_b ? 32'(bus.b_rdata_o) : 32'(bus.a_rdata_o),
             is_b ? 32'(8'h80 + 8'(j)) : 32'(8'h40 + 8'(j)));
         if (is_b) begin
            bus.b_addr_i = 16'h0200 + j + 16'd1;
            if (j == 16'd3) bus.b_req_i = 1'b0;
         end else begin
            bus.a_addr_i = 16'h0100 + j + 16'd1;
            if (j == 16'd3) bus.a_req_i = 1'b0;
         end
      end
      tick();
      chk("t4_idle_en", 32'(bus.mem_en_o), 32'h0);

      // A back-to-back alone, second issue goes through IDLE
      bus.a_req_i = 1'b1; bus.a_addr_i = 16'h0000;
      tick();
      chk("t5_en1", 32'(bus.mem_en_o), 32'h1);
      tick();
      chk("t5_ack1", 32'(bus.a_ack_o),   32'h1);
      chk("t5_rd1",  32'(bus.a_rdata_o), 32'h11);
      bus.a_addr_i = 16'h0001;
      tick();
      chk("t5_gap_en",  32'(bus.mem_en_o), 32'h0);
      chk("t5_gap_ack", 32'(bus.a_ack_o),  32'h0);
      tick();
      chk("t5_en2",   32'(bus.mem_en_o),   32'h1);
      chk("t5_addr2", 32'(bus.mem_addr_o), 32'h0001);
      tick();
      chk("t5_ack2", 32'(bus.a_ack_o),   32'h1);
      chk("t5_rd2",  32'(bus.a_rdata_o), 32'h22);
      bus.a_req_i = 1'b0;
      tick();

      // reset during ACCESS aborts the access
      bus.b_req_i = 1'b1; bus.b_we_i = 1'b0; bus.b_addr_i = 16'h0300;
      tick();
      chk("t6_en", 32'(bus.mem_en_o), 32'h1);
      rst = 1'b1;
      #1;
      chk("t6_en_drop", 32'(bus.mem_en_o), 32'h0);
      chk("t6_back0",   32'(bus.b_ack_o),  32'h0);
      tick();
      chk("t6_back1", 32'(bus.b_ack_o), 32'h0);
      rst = 1'b0;
      bus.b_req_i = 1'b0;
      tick();
      chk("t6_back2", 32'(bus.b_ack_o | bus.a_ack_o), 32'h0);
      chk("t6_en2",   32'(bus.mem_en_o), 32'h0);
      bus.a_req_i = 1'b1; bus.a_we_i = 1'b0; bus.a_addr_i = 16'h0400;
      bus.b_req_i = 1'b1; bus.b_addr_i = 16'h0500;
      tick();
      chk("t6_en3",  32'(bus.mem_en_o),   32'h1);
      chk("t6_addr", 32'(bus.mem_addr_o), 32'h0400);
      tick();
      chk("t6_aack", 32'(bus.a_ack_o),   32'h1);
      chk("t6_back", 32'(bus.b_ack_o),   32'h0);
      chk("t6_rd",   32'(bus.a_rdata_o), 32'h5A);
      bus.a_req_i = 1'b0;
      bus.b_req_i = 1'b0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
